// File: rtl/tohost_monitor_pkg.sv
// Shared types and constants for the tohost monitor: FSM encoding, pass value, default depth.
package tohost_monitor_pkg;

  localparam int unsigned DefaultDepth = 4;
  localparam logic [31:0] TohostPass   = 32'h0000_0001;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StDone
  } state_e;

  // A tohost write with bit 0 set terminates the program.
  function automatic logic is_terminal(logic [31:0] value);
    return value[0];
  endfunction

endpackage

// File: rtl/tohost_monitor_if.sv
// Event stream from the monitor to its consumer: valid/ready handshake carrying tohost values.
interface tohost_monitor_if #(
  parameter int unsigned Width = 32
);

  logic             evt_valid;
  logic [Width-1:0] evt_data;
  logic             evt_ready;

  modport master (
    output evt_valid,
    output evt_data,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_data,
    output evt_ready
  );

endinterface

// File: rtl/tohost_fifo.sv
// Synchronous event FIFO with extra-MSB pointers; head reads zero while empty.
module tohost_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [Width-1:0]         data_i,
  output logic                     accept_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic [Width-1:0]         head_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wptr_q, wptr_d;
  logic [AddrW:0]   rptr_q, rptr_d;
  logic             pop_eff;
  logic             push_eff;

  assign empty_o  = (wptr_q == rptr_q);
  assign full_o   = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                    (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign count_o  = wptr_q - rptr_q;

  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign pop_eff  = pop_i && !empty_o;
  assign push_eff = push_i && (!full_o || pop_eff);
  assign accept_o = push_eff;

  assign head_o   = empty_o ? '0 : mem_q[rptr_q[AddrW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_eff) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop_eff) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_eff) begin
      mem_q[wptr_q[AddrW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/tohost_monitor.sv
// Watches the tohost CSR, queues each change as an event and reports pass/fail on termination.
module tohost_monitor
  import tohost_monitor_pkg::*;
#(
  parameter int unsigned Depth = DefaultDepth
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   stall_i,
  input  logic [31:0]            csrd_tohost_i,
  tohost_monitor_if.master       evt_if,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [30:0]            fail_code_o,
  output logic                   overflow_o,
  output logic [15:0]            evt_count_o
);

  localparam int unsigned PtrW = $clog2(Depth) + 1;
  localparam logic [PtrW-1:0] OneEntry = PtrW'(1);

  state_e       state_q, state_d;
  logic [31:0]  last_val_q, last_val_d;
  logic         pass_q, pass_d;
  logic [30:0]  fail_code_q, fail_code_d;
  logic         overflow_q, overflow_d;
  logic [15:0]  evt_count_q, evt_count_d;

  logic            new_evt;
  logic            pop;
  logic            fifo_accept;
  logic            fifo_full;
  logic            fifo_empty;
  logic [PtrW-1:0] fifo_count;
  logic [31:0]     fifo_head;

  assign new_evt = (state_q == StRun) && !stall_i && (csrd_tohost_i != last_val_q);
  assign pop     = !fifo_empty && evt_if.evt_ready;

  tohost_fifo #(
    .Depth (Depth),
    .Width (32)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_i   (new_evt),
    .pop_i    (evt_if.evt_ready),
    .data_i   (csrd_tohost_i),
    .accept_o (fifo_accept),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count),
    .head_o   (fifo_head)
  );

  always_comb begin
    state_d     = state_q;
    last_val_d  = last_val_q;
    pass_d      = pass_q;
    fail_code_d = fail_code_q;
    overflow_d  = overflow_q;
    evt_count_d = evt_count_q;

    unique case (state_q)
      StRun: begin
        if (new_evt && is_terminal(csrd_tohost_i)) begin
          state_d     = StDrain;
          pass_d      = (csrd_tohost_i == TohostPass);
          fail_code_d = (csrd_tohost_i == TohostPass) ? '0 : csrd_tohost_i[31:1];
        end
      end
      StDrain: begin
        if (fifo_empty || ((fifo_count == OneEntry) && pop)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StRun;
      end
    endcase

    // A dropped event still updates last_val so the same value is not retried.
    if (new_evt) begin
      last_val_d = csrd_tohost_i;
      if (fifo_accept) begin
        if (evt_count_q != 16'hFFFF) begin
          evt_count_d = evt_count_q + 16'd1;
        end
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      last_val_q  <= '0;
      pass_q      <= 1'b0;
      fail_code_q <= '0;
      overflow_q  <= 1'b0;
      evt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      last_val_q  <= last_val_d;
      pass_q      <= pass_d;
      fail_code_q <= fail_code_d;
      overflow_q  <= overflow_d;
      evt_count_q <= evt_count_d;
    end
  end

  assign evt_if.evt_valid = !fifo_empty;
  assign evt_if.evt_data  = fifo_head;

  assign done_o      = (state_q == StDone);
  assign pass_o      = pass_q;
  assign fail_code_o = fail_code_q;
  assign overflow_o  = overflow_q;
  assign evt_count_o = evt_count_q;

  // fifo_full is implied by fifo_accept; kept visible for debug.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_tohost_monitor.sv
// Randomised and directed bench for tohost_monitor against a queue-based behavioural model.
module tb_tohost_monitor;

  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] tohost = '0;
  logic        done, pass, overflow;
  logic [30:0] fail_code;
  logic [15:0] evt_count;

  tohost_monitor_if evt_if ();

  tohost_monitor #(
    .Depth (Depth)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .stall_i       (stall),
    .csrd_tohost_i (tohost),
    .evt_if        (evt_if),
    .done_o        (done),
    .pass_o        (pass),
    .fail_code_o   (fail_code),
    .overflow_o    (overflow),
    .evt_count_o   (evt_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: a queue of retained events plus termination flags.
  logic [31:0] m_q[$];
  logic [31:0] m_last;
  bit          m_term, m_done, m_pass, m_ovf;
  logic [30:0] m_fail;
  int          m_count;

  task automatic model_reset();
    m_q.delete();
    m_last  = '0;
    m_term  = 0;
    m_done  = 0;
    m_pass  = 0;
    m_ovf   = 0;
    m_fail  = '0;
    m_count = 0;
  endtask

  task automatic cycle(input bit s, input bit rdy, input logic [31:0] v);
    int sz;
    bit pop, nev;
    stall = s;
    evt_if.evt_ready = rdy;
    tohost = v;
    sz  = m_q.size();
    pop = (sz > 0) && rdy;
    nev = !m_term && !s && (v != m_last);
    if (m_term && !m_done && (sz == 0 || (sz == 1 && pop))) m_done = 1;
    if (pop) void'(m_q.pop_front());
    if (nev) begin
      m_last = v;
      if (sz < Depth || pop) begin
        m_q.push_back(v);
        if (m_count < 65535) m_count++;
      end else begin
        m_ovf = 1;
      end
      if (v[0]) begin
        m_term = 1;
        m_pass = (v == 32'h1);
        m_fail = m_pass ? 31'h0 : v[31:1];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    tohost = '0;
    evt_if.evt_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    evt_if.evt_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (evt_if.evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", evt_if.evt_valid); end
    checks++; if (evt_if.evt_data !== 32'h0) begin failures++; $display("FAIL reset_data: got %0h want 0", evt_if.evt_data); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL reset_pass: got %0b want 0", pass); end
    checks++; if (fail_code !== 31'h0) begin failures++; $display("FAIL reset_fail_code: got %0h want 0", fail_code); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    checks++; if (evt_count !== 16'h0) begin failures++; $display("FAIL reset_count: got %0h want 0", evt_count); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_dedup();
    logic [31:0] stim [4] = '{32'h10, 32'h10, 32'h20, 32'h20};
    logic [31:0] want [2] = '{32'h10, 32'h20};
    logic [31:0] got[$];
    logic [31:0] obs;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      if (evt_if.evt_valid) got.push_back(evt_if.evt_data);
      cycle(0, 1, stim[i]);
    end
    checks++; if (got.size() != 2) begin failures++; $display("FAIL dedup_events: got %0d want 2", got.size()); end
    for (int i = 0; i < 2; i++) begin
      obs = (i < got.size()) ? got[i] : 32'hDEAD_BEEF;
      checks++; if (obs !== want[i]) begin failures++; $display("FAIL dedup_value%0d: got %0h want %0h", i, obs, want[i]); end
    end
    checks++; if (evt_count !== 16'd2) begin failures++; $display("FAIL dedup_count: got %0d want 2", evt_count); end
  endtask

  task automatic test_stall();
    apply_reset();
    cycle(1, 0, 32'h0);
    cycle(1, 0, 32'h5);
    cycle(1, 0, 32'h7);
    checks++; if (evt_if.evt_valid !== 1'b0) begin failures++; $display("FAIL stall_valid: got %0b want 0", evt_if.evt_valid); end
    checks++; if (evt_count !== 16'd0) begin failures++; $display("FAIL stall_count: got %0d want 0", evt_count); end
    cycle(0, 0, 32'h7);
    checks++; if (evt_if.evt_valid !== 1'b1) begin failures++; $display("FAIL stall_push_valid: got %0b want 1", evt_if.evt_valid); end
    checks++; if (evt_if.evt_data !== 32'h7) begin failures++; $display("FAIL stall_push_data: got %0h want 7", evt_if.evt_data); end
    cycle(0, 0, 32'h7);
    checks++; if (evt_count !== 16'd1) begin failures++; $display("FAIL stall_hold_count: got %0d want 1", evt_count); end
    checks++; if (evt_if.evt_data !== 32'h7) begin failures++; $display("FAIL stall_hold_data: got %0h want 7", evt_if.evt_data); end
  endtask

  task automatic test_overflow();
    logic [31:0] want [4] = '{32'h4, 32'h6, 32'h8, 32'hC};
    apply_reset();
    for (int i = 1; i <= 5; i++) cycle(0, 0, 32'(2 * i));
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
    checks++; if (evt_count !== 16'd4) begin failures++; $display("FAIL ovf_count: got %0d want 4", evt_count); end
    checks++; if (evt_if.evt_data !== 32'h2) begin failures++; $display("FAIL ovf_head: got %0h want 2", evt_if.evt_data); end
    // Push and pop together while full.
    cycle(0, 1, 32'hC);
    checks++; if (evt_count !== 16'd5) begin failures++; $display("FAIL full_pushpop_count: got %0d want 5", evt_count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (evt_if.evt_data !== want[i]) begin failures++; $display("FAIL ovf_order%0d: got %0h want %0h", i, evt_if.evt_data, want[i]); end
      cycle(0, 1, 32'hC);
    end
    checks++; if (evt_if.evt_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained: got %0b want 0", evt_if.evt_valid); end
    cycle(0, 1, 32'hC);
    checks++; if (evt_if.evt_valid !== 1'b0 || evt_count !== 16'd5) begin failures++; $display("FAIL empty_pop: got valid=%0b count=%0d want 0/5", evt_if.evt_valid, evt_count); end
  endtask

  task automatic test_pass();
    apply_reset();
    cycle(0, 0, 32'h2);
    cycle(0, 0, 32'h4);
    cycle(0, 0, 32'h1);
    checks++; if (done !== 1'b0 || pass !== 1'b1) begin failures++; $display("FAIL pass_latch: got done=%0b pass=%0b want 0/1", done, pass); end
    cycle(0, 0, 32'h40);
    checks++; if (evt_count !== 16'd3) begin failures++; $display("FAIL pass_drain_nosample: got %0d want 3", evt_count); end
    cycle(0, 1, 32'h40);
    cycle(0, 1, 32'h40);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL pass_early_done: got %0b want 0", done); end
    cycle(0, 1, 32'h40);
    checks++; if (done !== 1'b1 || pass !== 1'b1 || fail_code !== 31'h0) begin failures++; $display("FAIL pass_done: got done=%0b pass=%0b code=%0h want 1/1/0", done, pass, fail_code); end
  endtask

  task automatic test_fail();
    apply_reset();
    cycle(0, 1, 32'h2B);
    checks++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== 32'h2B) begin failures++; $display("FAIL fail_event: got v=%0b d=%0h want 1/2b", evt_if.evt_valid, evt_if.evt_data); end
    checks++; if (fail_code !== 31'h15 || pass !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL fail_latch: got code=%0h pass=%0b done=%0b want 15/0/0", fail_code, pass, done); end
    cycle(0, 1, 32'h2B);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL fail_done: got %0b want 1", done); end
    cycle(0, 1, 32'h100);
    cycle(0, 1, 32'h200);
    checks++; if (evt_if.evt_valid !== 1'b0 || evt_count !== 16'd1) begin failures++; $display("FAIL fail_no_sample: got v=%0b count=%0d want 0/1", evt_if.evt_valid, evt_count); end
    checks++; if (done !== 1'b1 || fail_code !== 31'h15) begin failures++; $display("FAIL fail_hold: got done=%0b code=%0h want 1/15", done, fail_code); end
  endtask

  task automatic test_reset_drain();
    apply_reset();
    cycle(0, 0, 32'h2);
    cycle(0, 0, 32'h4);
    cycle(0, 0, 32'h3);
    checks++; if (evt_if.evt_valid !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL rd_pre: got v=%0b done=%0b want 1/0", evt_if.evt_valid, done); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (evt_if.evt_valid !== 1'b0 || evt_if.evt_data !== 32'h0) begin failures++; $display("FAIL rd_async_fifo: got v=%0b d=%0h want 0/0", evt_if.evt_valid, evt_if.evt_data); end
    checks++; if (evt_count !== 16'h0 || fail_code !== 31'h0 || pass !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL rd_async_regs: got count=%0d code=%0h pass=%0b done=%0b ovf=%0b want zeros", evt_count, fail_code, pass, done, overflow);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cycle(0, 0, 32'h3);
    checks++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== 32'h3 || evt_count !== 16'd1) begin
      failures++; $display("FAIL rd_resume: got v=%0b d=%0h count=%0d want 1/3/1", evt_if.evt_valid, evt_if.evt_data, evt_count);
    end
  endtask

  task automatic test_random();
    logic [31:0] v, exp_data;
    bit s, r;
    apply_reset();
    for (int n = 0; n < 1500; n++) begin
      s = ($urandom_range(0, 3) == 0);
      r = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) v = $urandom_range(0, 1) ? 32'h1 : ($urandom() | 32'h1);
      else v = 32'($urandom_range(0, 7)) << 1;
      cycle(s, r, v);
      exp_data = (m_q.size() > 0) ? m_q[0] : 32'h0;
      checks++; if (evt_if.evt_valid !== (m_q.size() > 0)) begin failures++; $display("FAIL rnd_valid@%0d: got %0b want %0b", n, evt_if.evt_valid, m_q.size() > 0); end
      checks++; if (evt_if.evt_data !== exp_data) begin failures++; $display("FAIL rnd_data@%0d: got %0h want %0h", n, evt_if.evt_data, exp_data); end
      checks++; if (evt_count !== 16'(m_count)) begin failures++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, evt_count, m_count); end
      checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rnd_overflow@%0d: got %0b want %0b", n, overflow, m_ovf); end
      checks++; if (done !== m_done) begin failures++; $display("FAIL rnd_done@%0d: got %0b want %0b", n, done, m_done); end
      checks++; if (pass !== m_pass || fail_code !== m_fail) begin failures++; $display("FAIL rnd_result@%0d: got pass=%0b code=%0h want %0b/%0h", n, pass, fail_code, m_pass, m_fail); end
      if (m_done && $urandom_range(0, 7) == 0) apply_reset();
    end
  endtask

  initial begin
    evt_if.evt_ready = 1'b0;
    test_reset();
    test_dedup();
    test_stall();
    test_overflow();
    test_pass();
    test_fail();
    test_reset_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
